// File: rtl/uart_loopback_tester_if.sv
// Control, status and serial pins of uart_loopback_tester; directions are named from the tester's side.
// Build option LOOPBACK_LATENCY_EN adds max_latency_o.
interface uart_loopback_tester_if;
    logic        start_i;
    logic        rxd_i;
    logic        txd_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        timeout_o;
    logic [15:0] err_count_o;
    logic [15:0] byte_count_o;
`ifdef LOOPBACK_LATENCY_EN
    logic [31:0] max_latency_o;

    modport master (
        input  start_i, rxd_i,
        output txd_o, busy_o, done_o, pass_o, timeout_o, err_count_o, byte_count_o, max_latency_o
    );
    modport slave (
        output start_i, rxd_i,
        input  txd_o, busy_o, done_o, pass_o, timeout_o, err_count_o, byte_count_o, max_latency_o
    );
`else
    modport master (
        input  start_i, rxd_i,
        output txd_o, busy_o, done_o, pass_o, timeout_o, err_count_o, byte_count_o
    );
    modport slave (
        output start_i, rxd_i,
        input  txd_o, busy_o, done_o, pass_o, timeout_o, err_count_o, byte_count_o
    );
`endif
endinterface

// File: rtl/uart_loopback_tester.sv
// Stop-and-wait UART echo tester: sends an LFSR byte stream on txd and checks each echo on rxd.
// Build option LOOPBACK_LATENCY_EN adds a max round-trip latency tracker (max_latency_o).

module uart_loopback_tester_uart (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic [15:0] prescale_i,
    input  logic [7:0]  tx_tdata_i,
    input  logic        tx_tvalid_i,
    output logic        tx_tready_o,
    output logic        txd_o,
    input  logic        rxd_i,
    output logic [7:0]  rx_tdata_o,
    output logic        rx_tvalid_o
);
    logic [18:0] bit_cycles;
    logic [18:0] half_cycles;
    assign bit_cycles  = {prescale_i, 3'b000};
    assign half_cycles = {1'b0, prescale_i, 2'b00};

    logic [9:0]  tx_sh_q;
    logic [3:0]  tx_bits_q;
    logic [18:0] tx_cnt_q;
    logic        tx_busy_q;

    assign tx_tready_o = !tx_busy_q;
    assign txd_o       = tx_sh_q[0];

    // Transmit: shift register idles all-ones so the line is high out of reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tx_sh_q   <= '1;
            tx_bits_q <= '0;
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b0;
        end else if (!tx_busy_q) begin
            if (tx_tvalid_i) begin
                tx_sh_q   <= {1'b1, tx_tdata_i, 1'b0};
                tx_bits_q <= 4'd9;
                tx_cnt_q  <= bit_cycles - 19'd1;
                tx_busy_q <= 1'b1;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 19'd1;
        end else if (tx_bits_q == '0) begin
            tx_busy_q <= 1'b0;
        end else begin
            tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
            tx_bits_q <= tx_bits_q - 4'd1;
            tx_cnt_q  <= bit_cycles - 19'd1;
        end
    end

    logic [1:0]  rx_sync_q;
    logic        rx_active_q;
    logic [3:0]  rx_bits_q;
    logic [18:0] rx_cnt_q;
    logic [7:0]  rx_sh_q;
    logic [7:0]  rx_tdata_q;
    logic        rx_tvalid_q;
    logic        rxs;

    assign rxs         = rx_sync_q[1];
    assign rx_tdata_o  = rx_tdata_q;
    assign rx_tvalid_o = rx_tvalid_q;

    // Receive: sample mid-bit; a false start or bad stop bit drops the frame.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rx_sync_q   <= '1;
            rx_active_q <= 1'b0;
            rx_bits_q   <= '0;
            rx_cnt_q    <= '0;
            rx_sh_q     <= '0;
            rx_tdata_q  <= '0;
            rx_tvalid_q <= 1'b0;
        end else begin
            rx_sync_q   <= {rx_sync_q[0], rxd_i};
            rx_tvalid_q <= 1'b0;
            if (!rx_active_q) begin
                if (!rxs) begin
                    rx_active_q <= 1'b1;
                    rx_bits_q   <= '0;
                    rx_cnt_q    <= half_cycles - 19'd1;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 19'd1;
            end else begin
                rx_cnt_q <= bit_cycles - 19'd1;
                if (rx_bits_q == '0) begin
                    if (rxs) rx_active_q <= 1'b0;
                    else     rx_bits_q   <= 4'd1;
                end else if (rx_bits_q == 4'd9) begin
                    rx_active_q <= 1'b0;
                    if (rxs) begin
                        rx_tdata_q  <= rx_sh_q;
                        rx_tvalid_q <= 1'b1;
                    end
                end else begin
                    rx_sh_q   <= {rxs, rx_sh_q[7:1]};
                    rx_bits_q <= rx_bits_q + 4'd1;
                end
            end
        end
    end
endmodule

module uart_loopback_tester #(
    parameter real      CLK_FREQ       = 100.0e6,
    parameter int       BAUD_RATE      = 115200,
    parameter int       NUM_BYTES      = 256,
    parameter int       TIMEOUT_CYCLES = 1000000,
    parameter bit [7:0] LFSR_SEED      = 8'h01
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    uart_loopback_tester_if.master lt
);
    localparam int unsigned PRESCALE_INT = $rtoi(CLK_FREQ / (8.0 * BAUD_RATE));
    localparam logic [15:0] PRESCALE     = 16'(PRESCALE_INT);
    localparam logic [15:0] NUM_BYTES_W  = 16'(NUM_BYTES);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_NEXT, S_DONE} state_t;

    state_t      state_q;
    logic [7:0]  lfsr_q;
    logic [7:0]  expected_q;
    logic [7:0]  rx_data_q;
    logic [31:0] timer_q;
    logic [15:0] err_count_q;
    logic [15:0] byte_count_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        timeout_q;

    logic        arstn;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        txd;
    logic        rx_tvalid;
    logic [7:0]  rx_tdata;
    logic        start_ok;
    logic        lfsr_fb;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic [15:0] err_next;

    assign arstn     = ~arst_i;
    assign tx_tvalid = (state_q == S_SEND);
    assign start_ok  = lt.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // The rx side has no backpressure, so every rx beat is accepted as it arrives.
    uart_loopback_tester_uart u_uart (
        .clk_i       (clk_i),
        .arstn_i     (arstn),
        .prescale_i  (PRESCALE),
        .tx_tdata_i  (lfsr_q),
        .tx_tvalid_i (tx_tvalid),
        .tx_tready_o (tx_tready),
        .txd_o       (txd),
        .rxd_i       (lt.rxd_i),
        .rx_tdata_o  (rx_tdata),
        .rx_tvalid_o (rx_tvalid)
    );

    // Up to two error events can coincide: an unsolicited beat during a failing CHECK.
    always_comb begin
        err_inc = 2'd0;
        if (rx_tvalid && (state_q != S_WAIT))
            err_inc = err_inc + 2'd1;
        if ((state_q == S_CHECK) && (rx_data_q != expected_q))
            err_inc = err_inc + 2'd1;
        if ((state_q == S_WAIT) && !rx_tvalid && (timer_q == TIMEOUT_LAST))
            err_inc = err_inc + 2'd1;
    end

    assign err_sum  = {1'b0, err_count_q} + 17'(err_inc);
    assign err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            expected_q   <= '0;
            rx_data_q    <= '0;
            timer_q      <= '0;
            err_count_q  <= '0;
            byte_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            err_count_q <= err_next;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state_q      <= S_SEND;
                        lfsr_q       <= LFSR_SEED;
                        err_count_q  <= '0;
                        byte_count_q <= '0;
                        timeout_q    <= 1'b0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_tready) begin
                        expected_q   <= lfsr_q;
                        byte_count_q <= byte_count_q + 16'd1;
                        lfsr_q       <= {lfsr_q[6:0], lfsr_fb};
                        timer_q      <= '0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rx_tvalid) begin
                        rx_data_q <= rx_tdata;
                        state_q   <= S_CHECK;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_NEXT;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                S_CHECK: state_q <= S_NEXT;
                S_NEXT: begin
                    if (byte_count_q == NUM_BYTES_W) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_count_q == '0) && !timeout_q;
                    end else begin
                        state_q <= S_SEND;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LOOPBACK_LATENCY_EN
    logic [31:0] max_lat_q;
    logic [32:0] lat_sum;
    logic [31:0] lat_now;

    // timer_q reads 0 one cycle after the tx handshake, so the beat's latency is timer_q + 1.
    assign lat_sum = {1'b0, timer_q} + 33'd1;
    assign lat_now = lat_sum[32] ? 32'hFFFF_FFFF : lat_sum[31:0];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            max_lat_q <= '0;
        end else if (start_ok) begin
            max_lat_q <= '0;
        end else if ((state_q == S_WAIT) && rx_tvalid && (lat_now > max_lat_q)) begin
            max_lat_q <= lat_now;
        end
    end

    assign lt.max_latency_o = max_lat_q;
`endif

    assign lt.txd_o        = txd;
    assign lt.busy_o       = busy_q;
    assign lt.done_o       = done_q;
    assign lt.pass_o       = pass_q;
    assign lt.timeout_o    = timeout_q;
    assign lt.err_count_o  = err_count_q;
    assign lt.byte_count_o = byte_count_q;
endmodule

// File: tb/tb_uart_loopback_tester.sv
// Bench for uart_loopback_tester: decodes txd into a scoreboard and plays echo/inject/stuck line models on rxd.
module tb_uart_loopback_tester;
    localparam int BIT_CYC = 16;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    uart_loopback_tester_if lt();

    uart_loopback_tester #(
        .CLK_FREQ       (1.0e6),
        .BAUD_RATE      (62500),
        .NUM_BYTES      (4),
        .TIMEOUT_CYCLES (1000),
        .LFSR_SEED      (8'h01)
    ) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .lt     (lt)
    );

    int checks = 0;
    int errors = 0;

    int   rx_mode = 1;     // 0: stuck high, 1: txd wired to rxd, 2: device line
    logic dev_line = 1'b1;
    bit   echo_en  = 1'b0;
    bit   inv_en   = 1'b0;
    logic [7:0] inv_val = 8'h00;

    logic [7:0] tx_seen[$];
    logic [7:0] exp_q[$];
    logic [7:0] echo_q[$];
    logic [7:0] EXP_SEQ [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

    assign lt.rxd_i = (rx_mode == 1) ? lt.txd_o : ((rx_mode == 2) ? dev_line : 1'b1);

    // Serial monitor on txd.
    initial begin : mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (lt.txd_o === 1'b0) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    b[i] = lt.txd_o;
                end
                repeat (BIT_CYC) @(negedge clk);
                tx_seen.push_back(b);
                if (echo_en) echo_q.push_back(b);
            end
        end
    end

    // Echo device: retransmits queued bytes on dev_line, optionally corrupting one value.
    initial begin : dev
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (echo_q.size() > 0) begin
                b = echo_q.pop_front();
                if (inv_en && (b == inv_val)) b = ~b;
                dev_line = 1'b0;
                repeat (BIT_CYC) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    dev_line = b[i];
                    repeat (BIT_CYC) @(negedge clk);
                end
                dev_line = 1'b1;
                repeat (BIT_CYC) @(negedge clk);
            end
        end
    end

    task automatic pulse_start();
        lt.start_i = 1'b1;
        @(negedge clk);
        lt.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (lt.done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_bytes(input logic [15:0] n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (lt.byte_count_o === n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic push_expected();
        foreach (EXP_SEQ[i]) exp_q.push_back(EXP_SEQ[i]);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (lt.txd_o !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", lt.txd_o); end
        checks++; if (lt.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", lt.busy_o); end
        checks++; if (lt.done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", lt.done_o); end
        checks++; if (lt.pass_o !== 1'b0) begin errors++; $display("FAIL rst_pass got %b want 0", lt.pass_o); end
        checks++; if (lt.timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", lt.timeout_o); end
        checks++; if (lt.err_count_o !== 16'd0) begin errors++; $display("FAIL rst_err got %0d want 0", lt.err_count_o); end
        checks++; if (lt.byte_count_o !== 16'd0) begin errors++; $display("FAIL rst_bytes got %0d want 0", lt.byte_count_o); end
        arst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (lt.busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", lt.busy_o); end
    endtask

    task automatic test_loopback();
        bit ok;
        logic [7:0] a, e;
        rx_mode = 1;
        tx_seen.delete();
        exp_q.delete();
        push_expected();
        pulse_start();
        checks++; if (lt.busy_o !== 1'b1) begin errors++; $display("FAIL loop_busy got %b want 1", lt.busy_o); end
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL loop_done got 0 want 1 within bound"); end
        repeat (20) @(negedge clk);
        checks++; if (lt.pass_o !== 1'b1) begin errors++; $display("FAIL loop_pass got %b want 1", lt.pass_o); end
        checks++; if (lt.err_count_o !== 16'd0) begin errors++; $display("FAIL loop_err got %0d want 0", lt.err_count_o); end
        checks++; if (lt.byte_count_o !== 16'd4) begin errors++; $display("FAIL loop_bytes got %0d want 4", lt.byte_count_o); end
        checks++; if (lt.timeout_o !== 1'b0) begin errors++; $display("FAIL loop_timeout got %b want 0", lt.timeout_o); end
        checks++; if (lt.busy_o !== 1'b0) begin errors++; $display("FAIL loop_busy_end got %b want 0", lt.busy_o); end
`ifdef LOOPBACK_LATENCY_EN
        checks++;
        if ((lt.max_latency_o < 32'd144) || (lt.max_latency_o > 32'd192)) begin
            errors++; $display("FAIL loop_max_latency got %0d want 144..192", lt.max_latency_o);
        end
`endif
        checks++; if (tx_seen.size() != exp_q.size()) begin errors++; $display("FAIL loop_nbytes got %0d want %0d", tx_seen.size(), exp_q.size()); end
        while ((exp_q.size() > 0) && (tx_seen.size() > 0)) begin
            e = exp_q.pop_front(); a = tx_seen.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL loop_byte got %h want %h", a, e); end
        end
        exp_q.delete(); tx_seen.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        int last;
        logic [15:0] prev;
        logic [7:0] a, e;
        rx_mode = 0;
        tx_seen.delete();
        exp_q.delete();
        push_expected();
        pulse_start();
        last = -1;
        prev = 16'd0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (lt.done_o === 1'b1) begin ok = 1'b1; break; end
            if (lt.byte_count_o !== prev) begin
                if (last >= 0) begin
                    // WAIT (1000) + NEXT (1) + SEND (1) between handshakes.
                    checks++; if ((cyc - last) != 1002) begin errors++; $display("FAIL to_interval got %0d want 1002", cyc - last); end
                end
                last = cyc;
                prev = lt.byte_count_o;
            end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL to_done got 0 want 1 within bound"); end
        repeat (20) @(negedge clk);
        checks++; if (lt.timeout_o !== 1'b1) begin errors++; $display("FAIL to_timeout got %b want 1", lt.timeout_o); end
        checks++; if (lt.err_count_o !== 16'd4) begin errors++; $display("FAIL to_err got %0d want 4", lt.err_count_o); end
        checks++; if (lt.byte_count_o !== 16'd4) begin errors++; $display("FAIL to_bytes got %0d want 4", lt.byte_count_o); end
        checks++; if (lt.pass_o !== 1'b0) begin errors++; $display("FAIL to_pass got %b want 0", lt.pass_o); end
        checks++; if (tx_seen.size() != exp_q.size()) begin errors++; $display("FAIL to_nbytes got %0d want %0d", tx_seen.size(), exp_q.size()); end
        while ((exp_q.size() > 0) && (tx_seen.size() > 0)) begin
            e = exp_q.pop_front(); a = tx_seen.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL to_byte got %h want %h", a, e); end
        end
        exp_q.delete(); tx_seen.delete();
        rx_mode = 1;
    endtask

    task automatic test_mismatch();
        bit ok;
        logic [7:0] a, e;
        rx_mode = 2;
        inv_en  = 1'b1;
        inv_val = 8'h02;
        echo_en = 1'b1;
        tx_seen.delete();
        exp_q.delete();
        push_expected();
        pulse_start();
        wait_done(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mm_done got 0 want 1 within bound"); end
        repeat (20) @(negedge clk);
        checks++; if (lt.err_count_o !== 16'd1) begin errors++; $display("FAIL mm_err got %0d want 1", lt.err_count_o); end
        checks++; if (lt.pass_o !== 1'b0) begin errors++; $display("FAIL mm_pass got %b want 0", lt.pass_o); end
        checks++; if (lt.timeout_o !== 1'b0) begin errors++; $display("FAIL mm_timeout got %b want 0", lt.timeout_o); end
        checks++; if (lt.byte_count_o !== 16'd4) begin errors++; $display("FAIL mm_bytes got %0d want 4", lt.byte_count_o); end
        while ((exp_q.size() > 0) && (tx_seen.size() > 0)) begin
            e = exp_q.pop_front(); a = tx_seen.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL mm_byte got %h want %h", a, e); end
        end
        exp_q.delete(); tx_seen.delete();
        echo_en = 1'b0;
        inv_en  = 1'b0;
        repeat (200) @(negedge clk);
        rx_mode = 1;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        rx_mode = 1;
        pulse_start();
        wait_bytes(16'd2, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_reach_byte2 got 0 want 1 within bound"); end
        // Land inside data bit 0 of byte 02, where txd is low.
        repeat (20) @(negedge clk);
        checks++; if (lt.txd_o !== 1'b0) begin errors++; $display("FAIL mid_txd_before got %b want 0", lt.txd_o); end
        #1 arst = 1'b1;
        #1;
        checks++; if (lt.txd_o !== 1'b1) begin errors++; $display("FAIL mid_txd got %b want 1", lt.txd_o); end
        checks++; if (lt.busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", lt.busy_o); end
        checks++; if (lt.byte_count_o !== 16'd0) begin errors++; $display("FAIL mid_bytes got %0d want 0", lt.byte_count_o); end
        checks++; if (lt.err_count_o !== 16'd0) begin errors++; $display("FAIL mid_err got %0d want 0", lt.err_count_o); end
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (200) @(negedge clk);
        tx_seen.delete();
        exp_q.delete();
        test_loopback();
    endtask

    task automatic test_start_while_busy();
        bit ok;
        logic [7:0] a, e;
        rx_mode = 1;
        tx_seen.delete();
        exp_q.delete();
        push_expected();
        pulse_start();
        wait_bytes(16'd1, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sb_reach_byte1 got 0 want 1 within bound"); end
        repeat (10) @(negedge clk);
        pulse_start();
        checks++; if (lt.byte_count_o !== 16'd1) begin errors++; $display("FAIL sb_ignored_bytes got %0d want 1", lt.byte_count_o); end
        checks++; if (lt.busy_o !== 1'b1) begin errors++; $display("FAIL sb_ignored_busy got %b want 1", lt.busy_o); end
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sb_done got 0 want 1 within bound"); end
        repeat (20) @(negedge clk);
        checks++; if (lt.pass_o !== 1'b1) begin errors++; $display("FAIL sb_pass got %b want 1", lt.pass_o); end
        checks++; if (tx_seen.size() != exp_q.size()) begin errors++; $display("FAIL sb_nbytes got %0d want %0d", tx_seen.size(), exp_q.size()); end
        while ((exp_q.size() > 0) && (tx_seen.size() > 0)) begin
            e = exp_q.pop_front(); a = tx_seen.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL sb_byte got %h want %h", a, e); end
        end
        exp_q.delete(); tx_seen.delete();
        // Rerun from DONE replays the sequence from the seed.
        push_expected();
        pulse_start();
        checks++; if (lt.done_o !== 1'b0) begin errors++; $display("FAIL rerun_done got %b want 0", lt.done_o); end
        checks++; if (lt.byte_count_o !== 16'd0) begin errors++; $display("FAIL rerun_bytes got %0d want 0", lt.byte_count_o); end
        checks++; if (lt.busy_o !== 1'b1) begin errors++; $display("FAIL rerun_busy got %b want 1", lt.busy_o); end
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rerun_finish got 0 want 1 within bound"); end
        repeat (20) @(negedge clk);
        checks++; if (lt.byte_count_o !== 16'd4) begin errors++; $display("FAIL rerun_count got %0d want 4", lt.byte_count_o); end
        while ((exp_q.size() > 0) && (tx_seen.size() > 0)) begin
            e = exp_q.pop_front(); a = tx_seen.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL rerun_byte got %h want %h", a, e); end
        end
        exp_q.delete(); tx_seen.delete();
    endtask

    task automatic test_unsolicited();
        arst = 1'b1;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        rx_mode = 2;
        echo_en = 1'b0;
        @(negedge clk);
        echo_q.push_back(8'hA5);
        repeat (400) @(negedge clk);
        checks++; if (lt.err_count_o !== 16'd1) begin errors++; $display("FAIL uns_err got %0d want 1", lt.err_count_o); end
        checks++; if (lt.busy_o !== 1'b0) begin errors++; $display("FAIL uns_busy got %b want 0", lt.busy_o); end
        checks++; if (lt.byte_count_o !== 16'd0) begin errors++; $display("FAIL uns_bytes got %0d want 0", lt.byte_count_o); end
`ifdef LOOPBACK_LATENCY_EN
        checks++; if (lt.max_latency_o !== 32'd0) begin errors++; $display("FAIL uns_max_latency got %0d want 0", lt.max_latency_o); end
`endif
        rx_mode = 1;
    endtask

    initial begin
        lt.start_i = 1'b0;
        test_reset();
        test_loopback();
        test_timeout();
        test_mismatch();
        test_reset_midframe();
        test_start_while_busy();
        test_unsolicited();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
